// File: rtl/dmem_pkg.sv
// Shared definitions for the static data-memory arbiter: FSM encoding, port ids, memory window.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
    localparam int          DMEM_WORDS = 32;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational word-aligned window check: addr lies in [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4).
// Addresses below BASE_ADDR wrap in the subtraction and land far above the limit.
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int          DEPTH_WORDS = DMEM_WORDS
)
(
    input  logic [31:0] i_addr,
    output logic        o_valid
);

    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    logic [31:0] w_offset;

    assign w_offset = i_addr - BASE_ADDR;
    assign o_valid  = (i_addr[1:0] == 2'b00) && (w_offset < LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for the static data memory: one access at a time,
// IDLE -> ISSUE -> RESP for valid addresses (3 cycles), IDLE -> ERR for rejected ones (2 cycles).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int          DEPTH_WORDS = DMEM_WORDS
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addrRD,
    output logic [31:0] mem_addrWR,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_gnt;
    logic        r_win;
    logic        r_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_any_req;
    logic        w_win;
    logic        w_win_we;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_addr_ok;
    logic        w_ack;
    logic        w_err;
    logic [31:0] w_rdata;

    assign w_any_req   = a_req | b_req;
    // On contention the port opposite the last grant wins.
    assign w_win       = (b_req && (!a_req || (r_last_gnt == PORT_A))) ? PORT_B : PORT_A;
    assign w_win_we    = (w_win == PORT_B) ? b_we    : a_we;
    assign w_win_addr  = (w_win == PORT_B) ? b_addr  : a_addr;
    assign w_win_wdata = (w_win == PORT_B) ? b_wdata : a_wdata;

    dmem_addr_check #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_addr_check (
        .i_addr  (w_win_addr),
        .o_valid (w_addr_ok)
    );

    // Memory address/data registers only load for accepted requests, so they
    // keep the last issued values through ERR and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= PORT_B;
            r_win       <= PORT_A;
            r_we        <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_last_gnt <= w_win;
                r_win      <= w_win;
                r_we       <= w_win_we;
                if (w_addr_ok) begin
                    r_mem_addr  <= w_win_addr;
                    r_mem_wdata <= w_win_wdata;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ack          = 1'b0;
        w_err          = 1'b0;
        w_rdata        = 32'h0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_addrRD     = r_mem_addr;
        mem_addrWR     = r_mem_addr;
        mem_write_data = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_addr_ok ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE: begin
                mem_memwrite = r_we;
                mem_memread  = !r_we;
                w_state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                w_ack       = 1'b1;
                w_rdata     = r_we ? 32'h0 : mem_read_data;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_ack       = 1'b1;
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        a_ack   = w_ack && (r_win == PORT_A);
        a_err   = w_err && (r_win == PORT_A);
        a_rdata = (r_win == PORT_A) ? w_rdata : 32'h0;
        b_ack   = w_ack && (r_win == PORT_B);
        b_err   = w_err && (r_win == PORT_B);
        b_rdata = (r_win == PORT_B) ? w_rdata : 32'h0;
        busy    = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory; expected acks are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addrRD, mem_addrWR, mem_write_data, mem_read_data;
    logic        mem_memread, mem_memwrite, busy;

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .a_req          (a_req),
        .a_we           (a_we),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_ack          (a_ack),
        .a_err          (a_err),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_ack          (b_ack),
        .b_err          (b_err),
        .b_rdata        (b_rdata),
        .mem_addrRD     (mem_addrRD),
        .mem_addrWR     (mem_addrWR),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: registered read on posedge, write on negedge.
    always @(posedge clk) if (mem_memread) mem_read_data <= mem[mem_addrRD[6:2]];
    always @(negedge clk) if (mem_memwrite) mem[mem_addrWR[6:2]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit port, input bit err, input logic [31:0] rd, input int c);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mem_memread) begin
            rd_cnt++;
            last_rd_addr = mem_addrRD;
        end
        if (mem_memwrite) wr_cnt++;
        if (a_ack || b_ack) begin
            chk("ack_exclusive", 32'(a_ack && b_ack), 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {a_ack, b_ack}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_port",  32'(b_ack), 32'(mon_e.port));
                chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("ack_err",   32'(b_ack ? b_err : a_err), 32'(mon_e.err));
                chk("ack_rdata", b_ack ? b_rdata : a_rdata, mon_e.rdata);
                chk("loser_quiet", b_ack ? {a_err, a_rdata[30:0]} : {b_err, b_rdata[30:0]}, 32'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (port == 1'b0) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end
    endtask

    // One request from an otherwise idle port; ack expected 1 (error) or 2 cycles after sampling.
    task automatic single(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit err, input logic [31:0] rd);
        int lat;
        lat = err ? 1 : 2;
        push_exp(port, err, rd, cyc + lat);
        drive(port, 1'b1, we, addr, wd);
        step(lat + 1);
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
    endtask

    function automatic logic any_out();
        return |{a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, mem_addrRD, mem_addrWR,
                 mem_write_data, mem_memread, mem_memwrite, busy};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, r0, w0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_AAAA;
        mem[1] = 32'h0000_BBBB;
        mem[2] = 32'hCAFE_F00D;
        mem[3] = 32'hDEAD_BEEF;
        mem[5] = 32'h0BAD_C0DE;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
        step(3);
        chk("reset_outputs", 32'(any_out()), 32'h0);

        // Both ports held from reset: A first (last grant resets to B), then alternate.
        reset = 1'b0;
        base  = cyc;
        push_exp(1'b0, 1'b0, 32'h0000_AAAA, base + 2);
        push_exp(1'b1, 1'b0, 32'h0000_BBBB, base + 5);
        push_exp(1'b0, 1'b0, 32'h0000_AAAA, base + 8);
        push_exp(1'b1, 1'b0, 32'h0000_BBBB, base + 11);
        step(12);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);

        // Single read on A.
        r0 = rd_cnt;
        single(1'b0, 1'b0, 32'h1000_000C, 32'h0, 1'b0, 32'hDEAD_BEEF);
        chk("read_strobe_count", 32'(rd_cnt - r0), 32'd1);
        chk("read_strobe_addr", last_rd_addr, 32'h1000_000C);
        chk("addr_held_after", mem_addrRD, 32'h1000_000C);

        // Write then read back the top word on B.
        single(1'b1, 1'b1, 32'h1000_007C, 32'h1234_5678, 1'b0, 32'h0);
        single(1'b1, 1'b0, 32'h1000_007C, 32'h0, 1'b0, 32'h1234_5678);
        chk("mem_word31", mem[31], 32'h1234_5678);

        // Rejected addresses: one past the end, misaligned, below base.
        r0 = rd_cnt;
        w0 = wr_cnt;
        single(1'b0, 1'b0, 32'h1000_0080, 32'h0, 1'b1, 32'h0);
        single(1'b0, 1'b0, 32'h1000_0002, 32'h0, 1'b1, 32'h0);
        single(1'b0, 1'b1, 32'h0FFF_FFFC, 32'h5555_5555, 1'b1, 32'h0);
        chk("err_no_strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'h0);

        // A holds req through its ack and presents a new address in the following IDLE.
        base = cyc;
        push_exp(1'b0, 1'b0, 32'hCAFE_F00D, base + 2);
        push_exp(1'b0, 1'b0, 32'h0BAD_C0DE, base + 5);
        drive(1'b0, 1'b1, 1'b0, 32'h1000_0008, 32'h0);
        step(3);
        drive(1'b0, 1'b1, 1'b0, 32'h1000_0014, 32'h0);
        step(3);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);

        // Reset at the posedge ending ISSUE: write already committed, no ack.
        mem[4] = 32'h0;
        w0 = wr_cnt;
        drive(1'b0, 1'b1, 1'b1, 32'h1000_0010, 32'hA5A5_A5A5);
        step(1);
        chk("issue_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        chk("rst_issue_outputs", 32'(any_out()), 32'h0);
        reset = 1'b0;
        step(2);
        chk("rst_issue_word4", mem[4], 32'hA5A5_A5A5);
        chk("rst_issue_writes", 32'(wr_cnt - w0), 32'd1);

        // Make A the last grant, then reset at the posedge ending IDLE: nothing written.
        single(1'b0, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'h0000_BBBB);
        mem[4] = 32'h1111_1111;
        w0 = wr_cnt;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'h1000_0010, 32'h5A5A_5A5A);
        step(1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        chk("rst_idle_busy", 32'(busy), 32'h0);
        step(3);
        chk("rst_idle_word4", mem[4], 32'h1111_1111);
        chk("rst_idle_writes", 32'(wr_cnt - w0), 32'h0);

        // Contention after reset with two bad addresses: A first again, B two cycles later.
        base = cyc;
        push_exp(1'b0, 1'b1, 32'h0, base + 1);
        push_exp(1'b1, 1'b1, 32'h0, base + 3);
        drive(1'b0, 1'b1, 1'b0, 32'h1000_0080, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0);
        step(4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(3);

        chk("pending_acks", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller for the 32-word static data memory (byte addresses 0x10000000–0x1000007C).
- Port A is the CPU load/store path. Port B is the auxiliary path: display/debug readout, or a testbench loader.
- Arbitrates round-robin, validates addresses, sequences one memory access at a time, and returns read data with a one-cycle ack.
- Sits between the requesters and the memory's addrRD/addrWR/write_data/memread/memwrite/read_data interface.

Parameters:
- BASE_ADDR, 32'h10000000, byte address of word 0.
- DEPTH_WORDS, 32, number of addressable words; must be a power of 2.

Ports:
- clk  in  1  single clock; memory writes on negedge, reads on posedge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  port A request; held high, with fields stable, through its ack cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  32  byte address.
- a_wdata  in  32  write data.
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  high with a_ack when the address was rejected.
- a_rdata  out  32  read data, valid while a_ack is high.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- mem_addrRD  out  32  memory read address.
- mem_addrWR  out  32  memory write address.
- mem_write_data  out  32  memory write data.
- mem_memread  out  1  memory read strobe.
- mem_memwrite  out  1  memory write strobe.
- mem_read_data  in  32  memory registered read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the posedge of clk.
- Reset values: state=IDLE, last_gnt=B, all latched fields 0. All outputs 0: acks, errs, rdata, mem_* strobes, mem addresses, mem_write_data, busy.
- States: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the winner is the port opposite last_gnt.
  - At the posedge, latch winner id, we, addr, wdata; set last_gnt = winner.
  - Valid address: addr[1:0]==0 and (addr - BASE_ADDR) < DEPTH_WORDS*4 (unsigned 32-bit compare).
  - Valid -> ISSUE. Invalid -> ERR.
- ISSUE (1 cycle):
  - mem_addrRD = mem_addrWR = latched addr; mem_write_data = latched wdata.
  - mem_memwrite = we, mem_memread = !we, both decoded from registered state, so no glitches.
  - A write commits at this cycle's negedge. A read is captured by memory at the posedge ending ISSUE.
  - Next state: RESP.
- RESP (1 cycle):
  - Strobes low.
  - Winner's ack=1, err=0.
  - For a read, winner's rdata = mem_read_data. For a write, rdata=0.
  - Next state: IDLE.
- ERR (1 cycle):
  - No memory strobe.
  - Winner's ack=1, err=1, rdata=0.
  - Next state: IDLE.
- Latency, counted from the posedge that samples req in IDLE:
  - Valid access: ack in the 2nd following cycle.
  - Invalid access: ack in the next cycle.
  - Throughput: 3 cycles per valid access, 2 per error.
- The loser's request is not acknowledged. It stays pending and wins the next IDLE, because last_gnt has flipped.
- The non-winning port's ack/err/rdata stay 0 at all times.
- A req still high in the IDLE cycle after its ack is a new request.
- Request fields change only when the port is not in its ack-pending window. The arbiter uses latched copies after IDLE, so changes are harmless.
- mem_addrRD/addrWR/write_data hold their last issued values outside ISSUE; only the strobes return to 0.
- Reset mid-operation: return to IDLE on that edge, with no ack to either port. A write whose ISSUE negedge has already passed stays committed. last_gnt resets to B.
- An address equal to BASE_ADDR+DEPTH_WORDS*4 (0x10000080) is invalid.
- Addresses below BASE_ADDR wrap in the subtraction and are rejected.

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE/ISSUE/RESP/ERR, 2 bits), port-id constants PORT_A=0/PORT_B=1, DMEM_BASE=32'h10000000, DMEM_WORDS=32.
- One natural sub-module: dmem_addr_check, a combinational (addr) -> valid check using the pkg constants. It is reused by future I/O decoders.

Test Plan:
- Single read: preload word 3 = 0xDEADBEEF; A reads 0x1000000C -> mem_memread=1 for one cycle with addr 0x1000000C; a_ack=1, a_rdata=0xDEADBEEF two cycles after sampling; b_ack stays 0.
- Write then read: B writes 0x12345678 to 0x1000007C, then reads it -> b_ack after write with err=0; the read returns 0x12345678; word 31 of the memory model matches.
- Contention: both req from reset, A read 0x10000000 and B read 0x10000004 -> A is served first (last_gnt reset=B), then B; acks are 3 cycles apart. Holding both reqs continuously alternates A,B,A,B.
- Errors: A addr 0x10000080, 0x10000002, 0x0FFFFFFC -> each gives a_ack=1, a_err=1, a_rdata=0 one cycle after sampling; mem_memread and mem_memwrite never assert.
- Reset mid-transaction: A write 0xA5A5A5A5 to 0x10000010, reset asserted at the posedge ending ISSUE -> no a_ack, busy=0 and all outputs 0 next cycle, word 4 = 0xA5A5A5A5. Reset asserted at the posedge ending IDLE instead -> word 4 unchanged.
- Back-to-back same port: A holds req through ack with a new address -> a second transaction starts in the following IDLE; no duplicate ack for the first.
